// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack handshake,
// issues them to decode and applies the branch/jump redirect on acceptance.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_t;

    // Last wait-counter value before the timeout fires; meaningless when TIMEOUT is 0.
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT) - 32'd1;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_wait_cnt, w_wait_nxt;
    logic        r_fetch_err, w_err_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_jmp_target;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_br_target  = w_pc_plus4 + (branch_offset << 2);
    assign w_jmp_target = {w_pc_plus4[31:28], jump_target, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_instr     <= 32'h0;
            r_wait_cnt  <= 32'h0;
            r_fetch_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_instr     <= w_instr_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_fetch_err <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_wait_nxt  = r_wait_cnt;
        w_err_nxt   = r_fetch_err;
        case (r_state)
            S_IDLE: w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    w_instr_nxt = imem_rdata;
                    w_wait_nxt  = 32'h0;
                    w_state_nxt = S_ISSUE;
                end else if (TIMEOUT != 0 && r_wait_cnt == TO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_wait_nxt  = 32'h0;
                    w_state_nxt = S_HALT;
                end else begin
                    w_wait_nxt  = r_wait_cnt + 32'd1;
                end
            end
            S_ISSUE: begin
                // Jump outranks a taken branch when both are asserted.
                if (!stall) begin
                    if (jump)              w_pc_nxt = w_jmp_target;
                    else if (branch_taken) w_pc_nxt = w_br_target;
                    else                   w_pc_nxt = w_pc_plus4;
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_HALT;
        endcase
    end

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == S_ISSUE);
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, wait states, stall,
// branch/jump redirect, PC wrap, timeout and reset mid-fetch.
module tb_instr_fetch;

    logic        clk, rst;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, branch_taken, jump;
    logic [31:0] branch_offset;
    logic [25:0] jump_target;
    logic [31:0] instr, pc, pc_plus4;
    logic [5:0]  opcode;
    logic        instr_valid, fetch_err;

    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch #(.RESET_PC(32'h0), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_target(jump_target),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word derived from the address; opcode field = word index.
    function automatic logic [31:0] mw(input logic [31:0] a);
        return {a[7:2], a[27:2] ^ 26'h15A_5A5A};
    endfunction

    assign imem_rdata = mw(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: ack immediately, then accept the issued instruction with the given redirect.
    task automatic redirect(input logic j, input logic br, input logic [31:0] off, input logic [25:0] tgt);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        stall = 1'b0; jump = j; branch_taken = br; branch_offset = off; jump_target = tgt;
        step();
        jump = 1'b0; branch_taken = 1'b0; branch_offset = 32'h0; jump_target = 26'h0;
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_offset = 32'h0; jump_target = 26'h0;
        step(); step();

        chk("rst_req",   imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_pc",    pc, 32'h0);
        chk("rst_pc4",   pc_plus4, 32'h4);
        chk("rst_instr", instr, 32'h0);
        chk("rst_opc",   opcode, 6'h0);
        chk("rst_err",   fetch_err, 0);

        // Sequential zero-wait fetch
        rst = 1'b0; imem_ack = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("seq_req",   imem_req, 1);
            chk("seq_addr",  imem_addr, 32'(4 * i));
            chk("seq_nval",  instr_valid, 0);
            step();
            chk("seq_valid", instr_valid, 1);
            chk("seq_instr", instr, mw(32'(4 * i)));
            chk("seq_opc",   opcode, 6'(i));
            chk("seq_pc",    pc, 32'(4 * i));
            step();
        end

        // Wait states: ack on the third FETCH cycle
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ws_req",  imem_req, 1);
            chk("ws_addr", imem_addr, 32'h10);
            if (i == 2) imem_ack = 1'b1;
            step();
        end
        // Stall for two ISSUE cycles; redirect inputs must be ignored
        imem_ack = 1'b0; stall = 1'b1; jump = 1'b1; branch_taken = 1'b1;
        jump_target = 26'h3FF_FFFF; branch_offset = 32'h100;
        for (int i = 0; i < 3; i++) begin
            chk("st_valid", instr_valid, 1);
            chk("st_instr", instr, mw(32'h10));
            chk("st_pc",    pc, 32'h10);
            chk("st_req",   imem_req, 0);
            if (i == 2) begin
                stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
            end
            step();
        end
        chk("st_next_addr", imem_addr, 32'h14);
        chk("st_next_req",  imem_req, 1);

        // Branch: 0x14 -> 0x40, then backward and forward branches from 0x40
        redirect(1'b0, 1'b1, 32'd10, 26'h0);
        chk("br_to40", imem_addr, 32'h40);
        redirect(1'b0, 1'b1, 32'hFFFF_FFFE, 26'h0);
        chk("br_back", imem_addr, 32'h3C);
        redirect(1'b0, 1'b0, 32'h0, 26'h0);
        chk("br_seq",  imem_addr, 32'h40);
        redirect(1'b0, 1'b1, 32'h3, 26'h0);
        chk("br_fwd",  imem_addr, 32'h50);

        // Jump priority over taken branch from 0x9000_0010
        redirect(1'b0, 1'b1, 32'h23FF_FFEF, 26'h0);
        chk("j_setup", imem_addr, 32'h9000_0010);
        redirect(1'b1, 1'b1, 32'h0000_0040, 26'h000100);
        chk("j_prio",  imem_addr, 32'h9000_0400);

        // PC wrap at the top of the address space
        redirect(1'b0, 1'b1, 32'h1BFF_FEFE, 26'h0);
        chk("wr_setup", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        chk("wr_pc4", pc_plus4, 32'h0);
        step();
        chk("wr_addr", imem_addr, 32'h0);

        // Timeout: 4 FETCH cycles without ack
        for (int i = 0; i < 4; i++) begin
            chk("to_req", imem_req, 1);
            chk("to_err", fetch_err, 0);
            step();
        end
        chk("to_err_set", fetch_err, 1);
        chk("to_req_off", imem_req, 0);
        chk("to_nval",    instr_valid, 0);
        imem_ack = 1'b1;
        step(); step();
        chk("to_err_sticky", fetch_err, 1);
        chk("to_req_halt",   imem_req, 0);
        imem_ack = 1'b0; rst = 1'b1;
        step();
        chk("to_rst_err", fetch_err, 0);
        chk("to_rst_req", imem_req, 0);

        // Reset mid-fetch, late ack ignored
        rst = 1'b0;
        step();
        redirect(1'b1, 1'b0, 32'h0, 26'h000040);
        chk("rm_setup", imem_addr, 32'h100);
        chk("rm_req",   imem_req, 1);
        rst = 1'b1;
        step();
        chk("rm_req_off", imem_req, 0);
        chk("rm_pc",      pc, 32'h0);
        rst = 1'b0; imem_ack = 1'b1;
        step();
        chk("rm_instr", instr, 32'h0);
        chk("rm_nval",  instr_valid, 0);
        chk("rm_addr",  imem_addr, 32'h0);
        chk("rm_req2",  imem_req, 1);
        step();
        imem_ack = 1'b0;
        chk("rm_fetch", instr, mw(32'h0));
        chk("rm_valid", instr_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
